// File: rtl/lsu_sram_master.sv
// lsu_sram_master: RV32 load/store to SRAM_wrapper bridge with valid/ready request and response.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of force-aligning them.
module lsu_sram_master #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [31:0]       sram_bweb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [31:0]       sram_di,
    input  logic [31:0]       sram_do
);
    typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;
    state_t      state;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic        r_err;
    logic        r_we;
    logic [31:0] h_rdata;
    logic        h_err;
    logic        legal;
    logic        err;
    logic        acc;
    logic        act;
    logic        wr;
    logic [1:0]  off;
    logic [31:0] sh;
    logic [31:0] fmt;
    logic        unused;
    assign unused = ^req_addr[31:ADDR_W+2];
    assign legal = req_we ? (req_funct3 inside {3'd0, 3'd1, 3'd2})
                          : (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_TRAP_EN
    logic mis;
    assign mis = (req_funct3[1:0] == 2'd1 && req_addr[0]) || (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
    assign err = !legal || mis;
`else
    assign err = !legal;
`endif
    // byte offset within the word, force-aligned to the access size
    assign off = req_funct3[1:0] == 2'd0 ? req_addr[1:0] :
                 req_funct3[1:0] == 2'd1 ? {req_addr[1], 1'b0} : 2'd0;
    assign req_ready = !rst && (state == IDLE || (state == RESP && resp_ready));
    assign acc = req_valid && req_ready;
    assign act = acc && !err;
    assign wr = act && req_we;
    assign sram_ceb = !act;
    assign sram_web = !wr;
    assign sram_a = act ? req_addr[ADDR_W+1:2] : '0;
    assign sram_bweb = wr ? ~(req_funct3[1:0] == 2'd0 ? 32'h0000_00FF << {off, 3'b000} :
                              req_funct3[1:0] == 2'd1 ? 32'h0000_FFFF << {off, 3'b000} : 32'hFFFF_FFFF)
                          : 32'hFFFF_FFFF;
    assign sram_di = !wr ? 32'h0 :
                     req_funct3[1:0] == 2'd0 ? {4{req_wdata[7:0]}} :
                     req_funct3[1:0] == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
    assign sh = sram_do >> {r_off, 3'b000};
    assign fmt = (r_we || r_err) ? 32'h0 :
                 r_f3 == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
                 r_f3 == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
                 r_f3 == 3'b100 ? {24'h0, sh[7:0]} :
                 r_f3 == 3'b101 ? {16'h0, sh[15:0]} : sh;
    assign resp_valid = state != IDLE;
    assign resp_rdata = state == RESP ? fmt : state == HOLD ? h_rdata : 32'h0;
    assign resp_err = state == RESP ? r_err : state == HOLD ? h_err : 1'b0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            r_f3    <= 3'd0;
            r_off   <= 2'd0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            h_rdata <= 32'h0;
            h_err   <= 1'b0;
        end else begin
            if (acc) begin
                r_f3  <= req_funct3;
                r_off <= off;
                r_err <= err;
                r_we  <= req_we;
            end
            // DO is only valid in the cycle after the read, so a stalled response is latched
            if (state == RESP && !resp_ready) begin
                h_rdata <= fmt;
                h_err   <= r_err;
            end
            state <= acc ? RESP :
                     (state == RESP || state == HOLD) && !resp_ready ? HOLD : IDLE;
        end
    end
endmodule

// File: doc/lsu_sram_master.md
Name: lsu_sram_master

Overview:
- Initiator side of the SRAM_wrapper data-memory interface.
- Converts RV32 load/store requests from the CPU MEM stage into SRAM_wrapper control: CEB, WEB, BWEB, A, DI.
- Formats returned DO into sign- or zero-extended load data.
- Sits between the CPU core and DM1 inside top; gives a valid/ready request/response handshake to the pipeline.

Parameters:
- ADDR_W, 14, SRAM word-address width. Word address = req_addr[ADDR_W+1:2]; req_addr bits above ADDR_W+1 are ignored.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when valid&&ready
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal funct3 or misaligned access
- sram_ceb  out  1  SRAM chip enable, active low
- sram_web  out  1  SRAM write enable, active low (1=read)
- sram_bweb  out  32  per-bit write enable, active low
- sram_a  out  ADDR_W  SRAM word address
- sram_di  out  32  SRAM write data
- sram_do  in  32  SRAM read data, valid the cycle after a read-enabled edge

Behaviour:
- FSM states: IDLE, RESP, HOLD. Reset enters IDLE.
- Reset values: resp_valid=0, resp_err=0, resp_rdata=0.
- SRAM outputs while idle or in reset: ceb=1, web=1, bweb=32'hFFFFFFFF, a=0, di=0.
- rst=1 forces req_ready=0. Any pending response is dropped.
- req_ready=1 in IDLE, and in RESP when resp_ready=1. req_ready=0 in HOLD.
- Accept cycle N: the SRAM signals are driven combinationally from the request, so the SRAM samples them at the edge ending cycle N.
- Next state after accept is RESP. The request's funct3, addr[1:0], error flag and we are registered.
- Load accept: ceb=0, web=1, bweb all 1.
- Store accept: ceb=0, web=0.
  - SB: byte lane k=addr[1:0]; bweb[8k+7:8k]=0; di={4{wdata[7:0]}}.
  - SH: half lane addr[1]; bweb 16 bits =0; di={2{wdata[15:0]}}.
  - SW: bweb=0; di=wdata.
- Errors cause no SRAM access (ceb=1). Error conditions:
  - funct3 not in the load/store set. Loads allow 000, 001, 010, 100, 101; stores allow 000, 001, 010.
  - Misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
- RESP (cycle N+1): resp_valid=1.
  - Load: resp_rdata is sram_do shifted by the registered offset, then sign-extended (LB/LH) or zero-extended (LBU/LHU). LW passes sram_do through.
  - Store or error: rdata=0. resp_err = registered error flag.
- RESP with resp_ready=1 and req_valid=1 accepts the next request in the same cycle, giving back-to-back throughput of 1 per cycle. Stay in RESP.
- RESP with resp_ready=1 and no new request: go to IDLE.
- RESP with resp_ready=0: capture the formatted rdata/err into a hold register and go to HOLD. SRAM stays idle, since DO may not be relied on afterwards.
- HOLD: resp_valid=1 from the hold register. resp_ready=1 returns to IDLE.
- Response latency: exactly 1 cycle after accept when no backpressure.
- Ordering: responses are in request order. At most one outstanding request.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses produce resp_err=1 with no SRAM access, as described above.
- Undefined: misalignment is not an error. The offset is force-aligned: halves use addr[1] only; words use offset 0. The access proceeds normally. Illegal funct3 still errors.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> resp_valid=0, sram_ceb=1, sram_bweb=FFFFFFFF, req_ready=1.
- SW addr=0x10, wdata=0xDEADBEEF, then LW 0x10 -> store cycle: a=4, web=0, bweb=0, di=DEADBEEF. Next load response rdata=DEADBEEF, err=0.
- SB addr=0x13, wdata=0x000000AB, then LB 0x13 and LBU 0x13:
  - Store: bweb=00FFFFFF, di=ABABABAB.
  - LB -> FFFFFFAB.
  - LBU -> 000000AB.
- LH to 0x11 with LSU_MISALIGN_TRAP_EN defined -> ceb stays 1, resp_valid next cycle with err=1, rdata=0.
- Backpressure: LW 0x10 accepted, resp_ready=0 for 3 cycles while the SRAM DO input is changed externally -> resp_rdata stays DEADBEEF, req_ready=0 in HOLD. Released on resp_ready=1.
- Back-to-back: LW 0x0 then LW 0x4 in consecutive cycles with resp_ready=1 -> responses on consecutive cycles, in order. Assert rst during the second response -> resp_valid=0 the next cycle.
